// File: rtl/mux_scan_n_pkg.sv
// Shared definitions for the mux_scan_n channel multiplexer: mode encoding
// and the derived select-width helper.
package mux_scan_n_pkg;

  // Operating mode carried on the 2-bit mode input; the reserved code
  // behaves exactly like HOLD.
  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // Width of a channel index, never narrower than one bit.
  function automatic int sel_width(input int n_ch);
    return (n_ch > 2) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// Control/data bundle between a channel source and the mux_scan_n block.
// The master side drives channel data and controls, the slave side (the
// multiplexer) returns the registered sample and its status flags.
interface mux_scan_n_if
  import mux_scan_n_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int W       = 1,
  parameter int DWELL_W = 8
);

  localparam int SEL_W = sel_width(N_CH);

  logic [N_CH*W-1:0]  d;
  logic [SEL_W-1:0]   sel;
  logic [1:0]         mode;
  logic [DWELL_W-1:0] dwell;
  logic [N_CH-1:0]    ch_en;

  logic [W-1:0]       o_data;
  logic [SEL_W-1:0]   o_ch;
  logic               o_valid;
  logic               o_wrap;

  modport master (
    output d, sel, mode, dwell, ch_en,
    input  o_data, o_ch, o_valid, o_wrap
  );

  modport slave (
    input  d, sel, mode, dwell, ch_en,
    output o_data, o_ch, o_valid, o_wrap
  );

endinterface

// File: rtl/mux_next_ch.sv
// Combinational search for the next enabled channel strictly above cur,
// rotating back to the lowest enabled channel when none lies above.
module mux_next_ch #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0] cur,
  input  logic [N_CH-1:0]  ch_en,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic             none
);

  logic [SEL_W-1:0] above;
  logic [SEL_W-1:0] lowest;
  logic             found_above;

  // Scan from the top down so the last hit in each category is the lowest one.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    above       = '0;
    lowest      = '0;
    found_above = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_en[i]) begin
        lowest = SEL_W'(i);
        if (i > int'(cur)) begin
          above       = SEL_W'(i);
          found_above = 1'b1;
        end
      end
    end
    none = ~|ch_en;
    wrap = ~found_above & ~none;
    nxt  = found_above ? above : lowest;
  end

endmodule

// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered multiplexer with manual select, dwell-timed
// auto-scan over an enable mask, and a hold mode that freezes the sample.
module mux_scan_n
  import mux_scan_n_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int W       = 1,
  parameter int DWELL_W = 8
) (
  input logic         clk,
  input logic         rst,
  mux_scan_n_if.slave bus
);

  localparam int SEL_W = sel_width(N_CH);
  localparam int D_W   = N_CH * W;
  localparam int IDX_W = (D_W > 2) ? $clog2(D_W) : 1;

  // Registered state.
  logic [W-1:0]       data_q;
  logic [SEL_W-1:0]   ch_q;
  logic               valid_q;
  logic               wrap_q;
  logic [DWELL_W-1:0] cnt;
  logic               auto_q;   // previous cycle was AUTO; clear means this cycle enters AUTO

  // Next-state terms.
  mode_e              mode;
  logic [SEL_W-1:0]   ch_nxt;
  logic [DWELL_W-1:0] cnt_nxt;
  logic [DWELL_W-1:0] cnt_eff;
  logic               valid_nxt;
  logic               wrap_nxt;
  logic               load;
  logic [IDX_W-1:0]   base;

  // Scan helper outputs.
  logic [SEL_W-1:0]   scan_nxt;
  logic               scan_wrap;
  logic               scan_none;

  mux_next_ch #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_next_ch (
    .cur   (ch_q),
    .ch_en (bus.ch_en),
    .nxt   (scan_nxt),
    .wrap  (scan_wrap),
    .none  (scan_none)
  );

  assign mode = mode_e'(bus.mode);

  // Mode decode: choose the next channel, dwell count and status flags.
  always_comb begin
    ch_nxt    = ch_q;
    cnt_nxt   = cnt;
    valid_nxt = 1'b0;
    wrap_nxt  = 1'b0;
    load      = 1'b1;
    // A fresh entry into AUTO restarts the dwell count from zero.
    cnt_eff   = auto_q ? cnt : '0;
    unique case (mode)
      MODE_MANUAL: begin
        ch_nxt    = (int'(bus.sel) < N_CH) ? bus.sel : '0;
        valid_nxt = 1'b1;
        cnt_nxt   = '0;
      end
      MODE_AUTO: begin
        if (scan_none) begin
          cnt_nxt = '0;
        end else begin
          valid_nxt = 1'b1;
          // >= rather than == so a dwell shortened below the count advances at once.
          if ((!auto_q && !bus.ch_en[ch_q]) || (cnt_eff >= bus.dwell)) begin
            ch_nxt   = scan_nxt;
            wrap_nxt = scan_wrap;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt_eff + DWELL_W'(1);
          end
        end
      end
      default: begin
        // HOLD and the reserved code keep sample, channel and count.
        load = 1'b0;
      end
    endcase
    base = IDX_W'(int'(ch_nxt) * W);
  end

  // Output and dwell registers; async reset returns everything to channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt     <= '0;
      auto_q  <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      auto_q  <= (mode == MODE_AUTO);
      cnt     <= cnt_nxt;
      valid_q <= valid_nxt;
      wrap_q  <= wrap_nxt;
      if (load) begin
        ch_q   <= ch_nxt;
        data_q <= bus.d[base +: W];
      end
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_ch    = ch_q;
  assign bus.o_valid = valid_q;
  assign bus.o_wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Self-checking bench for mux_scan_n: directed scenarios followed by a
// randomized run, all compared against a behavioural channel-scan model.
module tb_mux_scan_n;
  import mux_scan_n_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mux_scan_n_if #(.N_CH(8), .W(4), .DWELL_W(8)) bus8 ();
  mux_scan_n_if #(.N_CH(6), .W(4), .DWELL_W(8)) bus6 ();

  mux_scan_n #(.N_CH(8), .W(4), .DWELL_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  mux_scan_n #(.N_CH(6), .W(4), .DWELL_W(8)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6.slave)
  );

  // Reference model of the 8-channel instance.
  int         m_ch;
  int         m_held;     // cycles already spent on m_ch in the current dwell window
  logic [3:0] m_data;
  logic       m_valid;
  logic       m_wrap;
  bit         m_in_auto;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lane(input int c);
    logic [31:0] v;
    v = bus8.d;
    return v[c*4 +: 4];
  endfunction

  // Next enabled channel walking upward modulo 8; wrapped when it is not above cur.
  function automatic int next_en(input int cur, input logic [7:0] en, output bit wrapped);
    int  c;
    bit  found;
    next_en = cur;
    wrapped = 1'b0;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      c = (cur + k) % 8;
      if (!found && en[c]) begin
        next_en = c;
        wrapped = (c <= cur);
        found   = 1'b1;
      end
    end
  endfunction

  task automatic model_reset();
    m_ch      = 0;
    m_held    = 0;
    m_data    = '0;
    m_valid   = 1'b0;
    m_wrap    = 1'b0;
    m_in_auto = 1'b0;
  endtask

  task automatic model_edge();
    bit w;
    int held;
    case (bus8.mode)
      2'b00: begin
        m_ch    = int'(bus8.sel);
        m_data  = lane(m_ch);
        m_valid = 1'b1;
        m_wrap  = 1'b0;
        m_held  = 0;
      end
      2'b01: begin
        if (bus8.ch_en == 8'h00) begin
          m_valid = 1'b0;
          m_wrap  = 1'b0;
          m_held  = 0;
        end else begin
          held = m_in_auto ? m_held : 0;
          if ((!m_in_auto && !bus8.ch_en[m_ch]) || held >= int'(bus8.dwell)) begin
            m_ch   = next_en(m_ch, bus8.ch_en, w);
            m_wrap = w;
            m_held = 0;
          end else begin
            m_wrap = 1'b0;
            m_held = held + 1;
          end
          m_valid = 1'b1;
        end
        m_data = lane(m_ch);
      end
      default: begin
        m_valid = 1'b0;
        m_wrap  = 1'b0;
      end
    endcase
    m_in_auto = (bus8.mode == 2'b01);
  endtask

  // One clock: advance the model at the edge, then compare just after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("o_data",  32'(bus8.o_data),  32'(m_data));
    check("o_ch",    32'(bus8.o_ch),    32'(m_ch));
    check("o_valid", 32'(bus8.o_valid), 32'(m_valid));
    check("o_wrap",  32'(bus8.o_wrap),  32'(m_wrap));
  endtask

  initial begin
    rst = 1'b1;
    bus8.d = '0; bus8.sel = '0; bus8.mode = MODE_AUTO; bus8.dwell = '0; bus8.ch_en = '0;
    bus6.d = '0; bus6.sel = '0; bus6.mode = MODE_MANUAL; bus6.dwell = '0; bus6.ch_en = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_data",  32'(bus8.o_data),  32'd0);
    check("rst_ch",    32'(bus8.o_ch),    32'd0);
    check("rst_valid", 32'(bus8.o_valid), 32'd0);
    check("rst_wrap",  32'(bus8.o_wrap),  32'd0);
    check("rst6_ch",   32'(bus6.o_ch),    32'd0);
    #4 rst = 1'b0;

    // Manual select, plus out-of-range select on the 6-channel instance.
    for (int k = 0; k < 8; k++) bus8.d[k*4 +: 4] = 4'(k + 1);
    for (int k = 0; k < 6; k++) bus6.d[k*4 +: 4] = 4'(k + 1);
    bus8.mode = MODE_MANUAL; bus8.sel = 3'd5;
    bus6.sel  = 3'd7;
    step();
    check("man_data",  32'(bus8.o_data),  32'd6);
    check("man_ch",    32'(bus8.o_ch),    32'd5);
    check("man_valid", 32'(bus8.o_valid), 32'd1);
    check("oor_ch",    32'(bus6.o_ch),    32'd0);
    check("oor_data",  32'(bus6.o_data),  32'd1);
    bus6.sel = 3'd4;
    step();
    check("man6_ch",   32'(bus6.o_ch),    32'd4);
    check("man6_data", 32'(bus6.o_data),  32'd5);

    // Mid-cycle reset while scanning.
    bus8.mode = MODE_AUTO; bus8.dwell = 8'd2; bus8.ch_en = 8'hFF;
    repeat (4) step();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("arst_data",  32'(bus8.o_data),  32'd0);
    check("arst_ch",    32'(bus8.o_ch),    32'd0);
    check("arst_valid", 32'(bus8.o_valid), 32'd0);
    check("arst_wrap",  32'(bus8.o_wrap),  32'd0);
    #2 rst = 1'b0;

    // Full scan at dwell=2: three cycles per channel, one wrap pulse on 7->0.
    for (int i = 0; i < 25; i++) begin
      step();
      check("scan_ch",   32'(bus8.o_ch),   32'(((i + 1) / 3) % 8));
      check("scan_wrap", 32'(bus8.o_wrap), 32'(i == 23));
    end

    // Sparse mask at dwell=0, then an empty mask.
    bus8.dwell = 8'd0; bus8.ch_en = 8'b1010_0100;
    for (int i = 0; i < 20 && bus8.o_ch != 3'd7; i++) step();
    check("sparse_reach7", 32'(bus8.o_ch), 32'd7);
    for (int i = 0; i < 6; i++) begin
      step();
      check("sparse_ch",   32'(bus8.o_ch),   (i % 3 == 0) ? 32'd2 : (i % 3 == 1) ? 32'd5 : 32'd7);
      check("sparse_wrap", 32'(bus8.o_wrap), 32'(i % 3 == 0));
    end
    bus8.ch_en = 8'h00;
    step();
    check("empty_valid", 32'(bus8.o_valid), 32'd0);
    check("empty_ch",    32'(bus8.o_ch),    32'd7);
    step();
    check("empty_ch2",   32'(bus8.o_ch),    32'd7);

    // Hold on channel 3 mid-dwell, then resume with a fresh count.
    for (int k = 0; k < 8; k++) bus8.d[k*4 +: 4] = 4'(k + 1);
    bus8.mode = MODE_MANUAL; bus8.sel = 3'd3;
    step();
    bus8.mode = MODE_AUTO; bus8.dwell = 8'd3; bus8.ch_en = 8'hFF;
    step();
    bus8.mode = MODE_HOLD;
    for (int i = 0; i < 4; i++) begin
      bus8.d = $urandom;
      if (i == 2) bus8.mode = MODE_RSVD;
      step();
      check("hold_data",  32'(bus8.o_data),  32'd4);
      check("hold_ch",    32'(bus8.o_ch),    32'd3);
      check("hold_valid", 32'(bus8.o_valid), 32'd0);
    end
    bus8.mode = MODE_AUTO;
    for (int i = 0; i < 3; i++) begin
      step();
      check("resume_ch", 32'(bus8.o_ch), 32'd3);
    end
    step();
    check("resume_adv", 32'(bus8.o_ch), 32'd4);

    // Dwell shortened below the running count.
    bus8.dwell = 8'd10;
    repeat (6) step();
    check("long_ch", 32'(bus8.o_ch), 32'd4);
    bus8.dwell = 8'd3;
    step();
    check("short_adv", 32'(bus8.o_ch), 32'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      check("short_hold", 32'(bus8.o_ch), 32'd5);
    end
    step();
    check("short_next", 32'(bus8.o_ch), 32'd6);

    // Randomized run with sticky modes and occasional mask changes.
    for (int i = 0; i < 600; i++) begin
      bus8.d   = $urandom;
      bus8.sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 9))
          0, 1:    bus8.mode = MODE_MANUAL;
          8:       bus8.mode = MODE_HOLD;
          9:       bus8.mode = MODE_RSVD;
          default: bus8.mode = MODE_AUTO;
        endcase
      end
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       bus8.ch_en = 8'h00;
          1:       bus8.ch_en = 8'(1 << $urandom_range(0, 7));
          default: bus8.ch_en = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 15) == 0) bus8.dwell = 8'($urandom_range(0, 3));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
